dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder: the target end of the processor's load/store request channel. It accepts one request at a time from the MEM stage (the EX/MEM outputs), holds it for a fixed latency, then commits the write or returns read data with a one-cycle response pulse. While a request is outstanding it drives `stall` so the pipeline freezes. It replaces the single-cycle data memory once the pipeline is complete.

## Interface
Parameters:
- `DEPTH_WORDS`, 64, number of 32-bit words; a power of two, at least 4.
- `LATENCY`, 2, cycles from request acceptance to the response pulse; at least 1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  a request is present on `req_*`.
- `req_ready`  out  1  the responder can accept a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte enables; bit i enables byte lane [8i+7:8i].
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  load data; valid only while `rsp_valid` = 1.
- `rsp_err`  out  1  the request faulted; valid only while `rsp_valid` = 1.
- `stall`  out  1  pipeline hold request.

## Operation
- Storage holds `DEPTH_WORDS` x 32 bits. The word index is `req_addr[log2(DEPTH_WORDS)+1:2]`.
- FSM states:
  - IDLE: `req_ready` = 1.
  - WAIT: counter active.
  - RESP: `rsp_valid` = 1.
- Acceptance happens when `req_valid` && `req_ready`. On acceptance, write, addr, wdata and be are captured into internal registers. `req_*` is ignored in WAIT and RESP.
- Transitions:
  - IDLE to WAIT on acceptance when `LATENCY` >= 2. The counter loads `LATENCY`-2.
  - IDLE to RESP on acceptance when `LATENCY` = 1.
  - WAIT to RESP when the counter is 0; otherwise the counter decrements.
  - RESP to IDLE unconditionally.
- Error check, from the captured address:
  - Misaligned: `addr[1:0]` != 0.
  - Out of range: `addr` >= 4*`DEPTH_WORDS`.
  - Either condition sets `rsp_err` = 1 in RESP. No memory write occurs and `rsp_rdata` = 0.
- Store with no error: on the RESP clock edge, each enabled byte lane of the word is overwritten with the matching lane of the captured wdata. Disabled lanes are unchanged. `rsp_rdata` = 0 for stores. A store with `be` = 0 completes normally with no change to memory.
- Load with no error: `rsp_rdata` = the full stored word during RESP, independent of `be`.
- `stall` = (IDLE && `req_valid`) || WAIT. It is 0 in RESP, so the pipeline advances on the same edge the response is consumed. There is no response back-pressure: the initiator must take the response in the RESP cycle.
- Reset:
  - FSM goes to IDLE, the counter clears, and all captured registers clear.
  - All storage words become 0.
  - A request in flight is dropped; its store is never committed.
  - Reset wins over a simultaneous `req_valid`.

## Timing
- Output values during and immediately after reset: `req_ready` = 1 (IDLE), `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0. `stall` = 0 while `req_valid` = 0; it is a combinational term, so it follows `req_valid` even in IDLE after reset.
- Latency: acceptance at edge t gives `rsp_valid` high in cycle t+`LATENCY`. Store data is visible to a load accepted at t+`LATENCY`+1 or later.
- Throughput: at most one request per `LATENCY`+1 cycles. `req_ready` is 0 in WAIT and RESP.
- `rsp_rdata` and `rsp_err` are registered outputs, or are decoded only from registered state; they have no combinational path from `req_*`.
- `stall` and `req_ready` are combinational from state and `req_valid` only.

## Test plan
- Reset, then store 0xDEADBEEF to addr 0x10 with `be`=0xF, then load 0x10 (`LATENCY`=2):
  - Store response: `rsp_valid` at acceptance+2 with `rsp_err`=0.
  - Load response: `rsp_rdata`=0xDEADBEEF at acceptance+2.
  - `stall` is high for exactly 2 cycles per request.
- Partial store: word 0x20 holds 0x11223344; store 0xAABBCCDD with `be`=0b0101, then load → 0x11BB33DD.
- Faults:
  - Load 0x12 (misaligned) → `rsp_err`=1, `rsp_rdata`=0.
  - Store to 0x100 (out of range, `DEPTH_WORDS`=64) → `rsp_err`=1; a subsequent check shows no word changed.
- Busy behaviour: `req_valid` held high continuously with changing `req_addr` → accepts occur every `LATENCY`+1 cycles, and each response matches the address captured at its acceptance.
- Reset mid-operation: accept a store to 0x04, assert `reset` in the WAIT cycle → no `rsp_valid`, `req_ready`=1 next cycle, and a later load of 0x04 returns 0.
- `LATENCY`=1 build: load accepted at t → `rsp_valid` at t+1, `stall` high only in the acceptance cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time, holds it for
// LATENCY cycles while stalling the pipeline, then commits the store or returns load data.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              be_q, be_d;
    logic [DEPTH_WORDS*32-1:0] mem_flat;

    logic          accept;
    logic          addr_err;
    logic          commit;
    logic [AW-1:0] widx;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_ready && req_valid;
    assign stall     = accept || (state_q == S_WAIT);

    // Fault and data decode look only at the captured request, never at req_*.
    assign widx      = addr_q[AW+1:2];
    assign addr_err  = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_err   = rsp_valid && addr_err;
    assign rsp_rdata = (rsp_valid && !write_q && !addr_err) ? mem_flat[{widx, 5'd0} +: 32] : '0;
    assign commit    = rsp_valid && write_q && !addr_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY >= 2) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // One register per word so the whole array can clear in a single reset cycle.
    for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_word
        logic [31:0] word_q, word_d;

        always_comb begin
            word_d = word_q;
            if (commit && (widx == AW'(g))) word_d = merge_lanes(word_q, wdata_q, be_q);
        end

        always_ff @(posedge clk) begin
            if (reset) word_q <= '0;
            else       word_q <= word_d;
        end

        assign mem_flat[g*32 +: 32] = word_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 main instance plus a LATENCY=1 build.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    int          nvec = 0;
    int          nmis = 0;

    // LATENCY = 2 instance
    logic        req_valid, req_ready, req_write, rsp_valid, rsp_err, stall;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;

    // LATENCY = 1 instance
    logic        v1, rdy1, wr1, rv1, err1, stall1;
    logic [31:0] addr1, wd1, rd1;
    logic [3:0]  be1;

    logic [31:0] busy_addr [9] = '{32'h30, 32'h13, 32'h200, 32'h34, 32'h10,
                                   32'h11, 32'h38, 32'h20, 32'h3};

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .stall(stall)
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(v1), .req_ready(rdy1), .req_write(wr1),
        .req_addr(addr1), .req_wdata(wd1), .req_be(be1),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1),
        .stall(stall1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left just after a rising edge with the LATENCY=2 responder idle.
    task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic [31:0] exp_rd, input logic exp_err);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".stall0"}, 32'(stall), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFF0; req_wdata = 32'h0BAD_0BAD; req_be = 4'hF;
        #1;
        chk({tag, ".wait_rv"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".stall1"}, 32'(stall), 32'd1);
        chk({tag, ".wait_rdy"}, 32'(req_ready), 32'd0);
        @(posedge clk); #2;
        chk({tag, ".rv"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rdata"}, rsp_rdata, exp_rd);
        chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, ".stall2"}, 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".idle_rv"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".idle_rdy"}, 32'(req_ready), 32'd1);
    endtask

    task automatic do_req1(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be,
                           input logic [31:0] exp_rd, input logic exp_err);
        v1 = 1'b1; wr1 = wr; addr1 = addr; wd1 = wd; be1 = be;
        #1;
        chk({tag, ".ready"}, 32'(rdy1), 32'd1);
        chk({tag, ".stall0"}, 32'(stall1), 32'd1);
        @(posedge clk); #1;
        v1 = 1'b0; addr1 = 32'h3;
        #1;
        chk({tag, ".rv"}, 32'(rv1), 32'd1);
        chk({tag, ".rdata"}, rd1, exp_rd);
        chk({tag, ".err"}, 32'(err1), 32'(exp_err));
        chk({tag, ".stall1"}, 32'(stall1), 32'd0);
        chk({tag, ".rdy_resp"}, 32'(rdy1), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".idle_rv"}, 32'(rv1), 32'd0);
        chk({tag, ".idle_rdy"}, 32'(rdy1), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        v1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0; be1 = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.rv", 32'(rsp_valid), 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.err", 32'(rsp_err), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.ready1", 32'(rdy1), 32'd1);

        // Request presented during reset must not be accepted.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
        #1;
        chk("rst.stall_follows", 32'(stall), 32'd1);
        @(posedge clk); #1;
        chk("rst.win_ready", 32'(req_ready), 32'd1);
        reset = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst.after_ready", 32'(req_ready), 32'd1);
        chk("rst.after_rv", 32'(rsp_valid), 32'd0);

        do_req("st_beef", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        do_req("ld_beef", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

        do_req("st_20", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
        do_req("st_20p", 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
        do_req("ld_20p", 1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0);

        do_req("ld_mis", 1'b0, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1);
        do_req("st_oor", 1'b1, 32'h100, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1);
        do_req("st_mis", 1'b1, 32'h11, 32'h5555_5555, 4'hF, 32'h0, 1'b1);
        do_req("ld_w0", 1'b0, 32'h0, 32'h0, 4'hF, 32'h0, 1'b0);
        do_req("ld_10k", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
        do_req("ld_20k", 1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0);
        do_req("ld_oor", 1'b0, 32'h104, 32'h0, 4'hF, 32'h0, 1'b1);

        do_req("st_be0", 1'b1, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
        do_req("ld_be0", 1'b0, 32'h10, 32'h0, 4'h3, 32'hDEAD_BEEF, 1'b0);

        do_req("st_30", 1'b1, 32'h30, 32'h3030_A0A0, 4'hF, 32'h0, 1'b0);
        do_req("st_34", 1'b1, 32'h34, 32'h3434_B1B1, 4'hF, 32'h0, 1'b0);
        do_req("st_38", 1'b1, 32'h38, 32'h3838_C2C2, 4'hF, 32'h0, 1'b0);

        // Continuous req_valid with a new address every cycle: accepts at c = 0, 3, 6.
        req_valid = 1'b1; req_write = 1'b0; req_be = 4'hF; req_wdata = '0;
        for (int c = 0; c < 9; c++) begin
            req_addr = busy_addr[c];
            #1;
            if (c % 3 == 0) begin
                chk($sformatf("busy%0d.ready", c), 32'(req_ready), 32'd1);
                chk($sformatf("busy%0d.stall", c), 32'(stall), 32'd1);
            end else if (c % 3 == 1) begin
                chk($sformatf("busy%0d.ready", c), 32'(req_ready), 32'd0);
                chk($sformatf("busy%0d.rv", c), 32'(rsp_valid), 32'd0);
            end else begin
                chk($sformatf("busy%0d.rv", c), 32'(rsp_valid), 32'd1);
                chk($sformatf("busy%0d.stall", c), 32'(stall), 32'd0);
                chk($sformatf("busy%0d.err", c), 32'(rsp_err), 32'd0);
                chk($sformatf("busy%0d.rdata", c), rsp_rdata,
                    (c == 2) ? 32'h3030_A0A0 : (c == 5) ? 32'h3434_B1B1 : 32'h3838_C2C2);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        #1;
        chk("busy.end_ready", 32'(req_ready), 32'd1);

        do_req1("l1_st", 1'b1, 32'h8, 32'h5A5A_A5A5, 4'hF, 32'h0, 1'b0);
        do_req1("l1_ld", 1'b0, 32'h8, 32'h0, 4'hF, 32'h5A5A_A5A5, 1'b0);
        do_req1("l1_mis", 1'b0, 32'h9, 32'h0, 4'hF, 32'h0, 1'b1);

        // Reset during WAIT drops the in-flight store.
        #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'h1234_5678; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0; reset = 1'b1;
        #1;
        chk("mid.wait_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("mid.rv", 32'(rsp_valid), 32'd0);
        chk("mid.ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("mid.rv_late", 32'(rsp_valid), 32'd0);
        do_req("mid_ld4", 1'b0, 32'h4, 32'h0, 4'hF, 32'h0, 1'b0);
        do_req("mid_ld10", 1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0);
        do_req1("mid_l1", 1'b0, 32'h8, 32'h0, 4'hF, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
